// File: rtl/vec_order_checker.sv
// ============================================================================
// Module   : vec_order_checker
// Brief    : Checks that four 5-bit counter lanes (mixed index ranges) only
//            ever step by +1 mod 32; captures the first failure, counts changes.
//            Optional cross-lane equality check under `VEC_CHK_CROSS_EN`.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_order_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [4:0]       lane_40,
   input  logic [0:4]       lane_04,
   input  logic [5:1]       lane_51,
   input  logic [1:5]       lane_15,
   output logic [1:0]       state,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [4:0]       err_exp,
   output logic [4:0]       err_got,
   output logic [CNT_W-1:0] evt_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEED  = 2'd1,
      S_TRACK = 2'd2,
      S_FAIL  = 2'd3
   } state_t;

   state_t     st;
   logic [4:0] cur  [4];
   logic [4:0] prev [4];
   logic [4:0] nxt  [4];
   logic [3:0] chg;
   logic [3:0] bad;
   logic [2:0] nchg;
   logic [CNT_W:0]   cnt_sum;
   logic [CNT_W-1:0] cnt_next;

   logic       fail_hit;
   logic [2:0] fail_code;
   logic [4:0] fail_exp;
   logic [4:0] fail_got;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign nxt[i] = prev[i] + 5'd1;
      assign chg[i] = (cur[i] != prev[i]);
      assign bad[i] = chg[i] && (cur[i] != nxt[i]);
   end

   assign nchg     = 3'(chg[0]) + 3'(chg[1]) + 3'(chg[2]) + 3'(chg[3]);
   assign cnt_sum  = {1'b0, evt_cnt} + {{(CNT_W-2){1'b0}}, nchg};
   // A carry out of the counter width means the count saturates.
   assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

   always_comb begin
      fail_hit  = 1'b0;
      fail_code = 3'd0;
      fail_exp  = 5'd0;
      fail_got  = 5'd0;
      // Descending scan so the lowest failing lane wins.
      for (int i = 3; i >= 0; i--) begin
         if (bad[i]) begin
            fail_hit  = 1'b1;
            fail_code = 3'(i + 1);
            fail_exp  = nxt[i];
            fail_got  = cur[i];
         end
      end
`ifdef VEC_CHK_CROSS_EN
      if (!fail_hit && (chg == 4'd0)) begin
         for (int i = 3; i >= 1; i--) begin
            if (cur[i] != cur[0]) begin
               fail_hit  = 1'b1;
               fail_code = 3'd5;
               fail_exp  = cur[0];
               fail_got  = cur[i];
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= S_IDLE;
         err      <= 1'b0;
         err_code <= 3'd0;
         err_exp  <= 5'd0;
         err_got  <= 5'd0;
         evt_cnt  <= '0;
         for (int i = 0; i < 4; i++) begin
            cur[i]  <= 5'd0;
            prev[i] <= 5'd0;
         end
      end else begin
         // Positional assignment maps each lane's leftmost index to the MSB.
         cur[0] <= lane_40;
         cur[1] <= lane_04;
         cur[2] <= lane_51;
         cur[3] <= lane_15;
         for (int i = 0; i < 4; i++) prev[i] <= cur[i];

         if (!en) begin
            st <= S_IDLE;
         end else begin
            case (st)
               S_IDLE: st <= S_SEED;
               S_SEED: begin
                  err      <= 1'b0;
                  err_code <= 3'd0;
                  err_exp  <= 5'd0;
                  err_got  <= 5'd0;
                  evt_cnt  <= '0;
                  st       <= S_TRACK;
               end
               S_TRACK: begin
                  evt_cnt <= cnt_next;
                  if (fail_hit) begin
                     err      <= 1'b1;
                     err_code <= fail_code;
                     err_exp  <= fail_exp;
                     err_got  <= fail_got;
                     st       <= S_FAIL;
                  end
               end
               S_FAIL:  st <= S_FAIL;
               default: st <= S_IDLE;
            endcase
         end
      end
   end

   assign state = st;

endmodule

`default_nettype wire

// File: tb/tb_vec_order_checker.sv
// ============================================================================
// Module   : tb_vec_order_checker
// Brief    : Self-checking bench for vec_order_checker: vector table, directed
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vec_order_checker;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [4:0]  lane_40;
   logic [0:4]  lane_04;
   logic [5:1]  lane_51;
   logic [1:5]  lane_15;

   logic [1:0]  state;
   logic        err;
   logic [2:0]  err_code;
   logic [4:0]  err_exp;
   logic [4:0]  err_got;
   logic [15:0] evt_cnt;

   logic [1:0]  s_state;
   logic        s_err;
   logic [2:0]  s_err_code;
   logic [4:0]  s_err_exp;
   logic [4:0]  s_err_got;
   logic [3:0]  s_evt_cnt;

   vec_order_checker #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .lane_40(lane_40), .lane_04(lane_04), .lane_51(lane_51), .lane_15(lane_15),
      .state(state), .err(err), .err_code(err_code), .err_exp(err_exp),
      .err_got(err_got), .evt_cnt(evt_cnt)
   );

   // Narrow-counter instance sharing the stimulus, used for saturation.
   vec_order_checker #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .en(en),
      .lane_40(lane_40), .lane_04(lane_04), .lane_51(lane_51), .lane_15(lane_15),
      .state(s_state), .err(s_err), .err_code(s_err_code), .err_exp(s_err_exp),
      .err_got(s_err_got), .evt_cnt(s_evt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: spec-level view with plain integers.
   int m_st, m_err, m_code, m_exp, m_got, m_raw;
   int m_cur[4];
   int m_prev[4];
   int v[4];

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic model_reset();
      m_st = 0; m_err = 0; m_code = 0; m_exp = 0; m_got = 0; m_raw = 0;
      for (int i = 0; i < 4; i++) begin
         m_cur[i] = 0;
         m_prev[i] = 0;
      end
   endtask

   task automatic model_edge();
      int  nchg;
      bit  hit;
      if (!en) m_st = 0;
      else if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
         m_err = 0; m_code = 0; m_exp = 0; m_got = 0; m_raw = 0; m_st = 2;
      end else if (m_st == 2) begin
         nchg = 0;
         hit  = 0;
         for (int i = 0; i < 4; i++) begin
            if (m_cur[i] != m_prev[i]) begin
               nchg++;
               if (!hit && m_cur[i] != (m_prev[i] + 1) % 32) begin
                  hit = 1; m_code = i + 1; m_exp = (m_prev[i] + 1) % 32; m_got = m_cur[i];
               end
            end
         end
`ifdef VEC_CHK_CROSS_EN
         if (nchg == 0) begin
            for (int i = 1; i < 4; i++) begin
               if (!hit && m_cur[i] != m_cur[0]) begin
                  hit = 1; m_code = 5; m_exp = m_cur[0]; m_got = m_cur[i];
               end
            end
         end
`endif
         m_raw += nchg;
         if (hit) begin
            m_err = 1;
            m_st  = 3;
         end
      end
      for (int i = 0; i < 4; i++) begin
         m_prev[i] = m_cur[i];
         m_cur[i]  = v[i];
      end
   endtask

   task automatic drive(input bit e, input int a, input int b, input int c, input int d);
      en = e;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      lane_40 = 5'(a);
      lane_04 = 5'(b);
      lane_51 = 5'(c);
      lane_15 = 5'(d);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_all(input string name);
      chk({name, ".state"},    int'(state),    m_st);
      chk({name, ".err"},      int'(err),      m_err);
      chk({name, ".err_code"}, int'(err_code), m_code);
      chk({name, ".err_exp"},  int'(err_exp),  m_exp);
      chk({name, ".err_got"},  int'(err_got),  m_got);
      chk({name, ".evt_cnt"},  int'(evt_cnt),  (m_raw > 65535) ? 65535 : m_raw);
      chk({name, ".evt_sat"},  int'(s_evt_cnt), (m_raw > 15) ? 15 : m_raw);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      lane_40 = 5'($urandom); lane_04 = 5'($urandom);
      lane_51 = 5'($urandom); lane_15 = 5'($urandom);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit e;
      int l0, l1, l2, l3;
      int st, er, code, ex, gt, cnt;
   } vec_t;

   function automatic vec_t mk(bit e, int l0, int l1, int l2, int l3,
                               int st, int er, int code, int ex, int gt, int cnt);
      vec_t r;
      r.e = e; r.l0 = l0; r.l1 = l1; r.l2 = l2; r.l3 = l3;
      r.st = st; r.er = er; r.code = code; r.ex = ex; r.gt = gt; r.cnt = cnt;
      return r;
   endfunction

   vec_t tbl[16];

   initial begin
      tbl[0]  = mk(0, 0,0,0,0, 0,0,0,0,0,0);
      tbl[1]  = mk(1, 0,0,0,0, 1,0,0,0,0,0);
      tbl[2]  = mk(1, 1,0,0,0, 2,0,0,0,0,0);
      tbl[3]  = mk(1, 1,1,0,0, 2,0,0,0,0,1);
      tbl[4]  = mk(1, 1,1,1,1, 2,0,0,0,0,2);
      tbl[5]  = mk(1, 1,1,1,1, 2,0,0,0,0,4);
      tbl[6]  = mk(1, 2,2,2,2, 2,0,0,0,0,4);
      tbl[7]  = mk(1, 2,2,2,2, 2,0,0,0,0,8);
      tbl[8]  = mk(1, 2,2,2,2, 2,0,0,0,0,8);
      tbl[9]  = mk(1, 2,4,2,2, 2,0,0,0,0,8);
      tbl[10] = mk(1, 2,4,2,2, 3,1,2,3,4,9);
      tbl[11] = mk(1, 3,3,3,3, 3,1,2,3,4,9);
      tbl[12] = mk(0, 3,3,3,3, 0,1,2,3,4,9);
      tbl[13] = mk(1, 3,3,3,3, 1,1,2,3,4,9);
      tbl[14] = mk(1, 3,3,3,3, 2,0,0,0,0,0);
      tbl[15] = mk(1, 3,3,3,3, 2,0,0,0,0,0);

      // Vector table
      do_reset();
      chk("rst.state", int'(state), 0);
      chk("rst.evt_cnt", int'(evt_cnt), 0);
      for (int r = 0; r < 16; r++) begin
         drive(tbl[r].e, tbl[r].l0, tbl[r].l1, tbl[r].l2, tbl[r].l3);
         chk($sformatf("tbl%0d.state", r),    int'(state),    tbl[r].st);
         chk($sformatf("tbl%0d.err", r),      int'(err),      tbl[r].er);
         chk($sformatf("tbl%0d.err_code", r), int'(err_code), tbl[r].code);
         chk($sformatf("tbl%0d.err_exp", r),  int'(err_exp),  tbl[r].ex);
         chk($sformatf("tbl%0d.err_got", r),  int'(err_got),  tbl[r].gt);
         chk($sformatf("tbl%0d.evt_cnt", r),  int'(evt_cnt),  tbl[r].cnt);
      end

      // Lockstep count with wrap; narrow counter saturates
      do_reset();
      for (int s = 0; s <= 40; s++)
         for (int k = 0; k < 10; k++) drive(1, s % 32, s % 32, s % 32, s % 32);
      chk("lock.err", int'(err), 0);
      chk("lock.evt_cnt", int'(evt_cnt), 160);
      chk("lock.state", int'(state), 2);
      chk("lock.evt_sat", int'(s_evt_cnt), 15);
      check_all("lock");

      // Ascending lane step error, then async reset mid-FAIL
      do_reset();
      repeat (4) drive(1, 6, 6, 6, 6);
      drive(1, 6, 8, 6, 6);
      chk("asc.early_err", int'(err), 0);
      drive(1, 6, 8, 6, 6);
      chk("asc.err", int'(err), 1);
      chk("asc.err_code", int'(err_code), 2);
      chk("asc.err_exp", int'(err_exp), 7);
      chk("asc.err_got", int'(err_got), 8);
      chk("asc.state", int'(state), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async.state", int'(state), 0);
      chk("async.err", int'(err), 0);
      chk("async.err_code", int'(err_code), 0);
      chk("async.err_exp", int'(err_exp), 0);
      chk("async.evt_cnt", int'(evt_cnt), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Simultaneous failures, re-enable through SEED
      do_reset();
      repeat (4) drive(1, 3, 3, 3, 3);
      drive(1, 3, 3, 5, 0);
      drive(1, 3, 3, 5, 0);
      chk("sim.err_code", int'(err_code), 3);
      chk("sim.err_exp", int'(err_exp), 4);
      chk("sim.err_got", int'(err_got), 5);
      drive(0, 3, 3, 5, 0);
      drive(1, 3, 3, 5, 0);
      chk("sim.seed_state", int'(state), 1);
      drive(1, 3, 3, 5, 0);
      chk("sim.reen_err", int'(err), 0);
      chk("sim.reen_cnt", int'(evt_cnt), 0);
      chk("sim.reen_state", int'(state), 2);
      // Async reset mid-TRACK with a non-zero count
      drive(1, 4, 3, 5, 0);
      drive(1, 4, 3, 5, 0);
      chk("trk.evt_cnt", int'(evt_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_trk.state", int'(state), 0);
      chk("async_trk.evt_cnt", int'(evt_cnt), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Cross-lane mismatch with no change
      do_reset();
      repeat (5) drive(1, 9, 9, 9, 10);
`ifdef VEC_CHK_CROSS_EN
      chk("cross.err", int'(err), 1);
      chk("cross.err_code", int'(err_code), 5);
      chk("cross.err_exp", int'(err_exp), 9);
      chk("cross.err_got", int'(err_got), 10);
`else
      chk("cross.err", int'(err), 0);
      chk("cross.state", int'(state), 2);
`endif
      check_all("cross");

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4; i++) v[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         int nv[4];
         int r;
         for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      nv[i] = v[i];
            else if (r < 96) nv[i] = (v[i] + 1) % 32;
            else             nv[i] = int'($urandom_range(0, 31));
         end
         drive($urandom_range(0, 39) != 0, nv[0], nv[1], nv[2], nv[3]);
         check_all($sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
